rw_mlp_feature_loader: RTL and testbench

- Upstream feeder for the combinational red-wine MLP regressor.
- Accepts raw 8-bit feature samples serially, one per valid/ready beat. Quantizes each to the regressor's 4-bit unsigned input format and packs 11 of them into the 44-bit feature vector.
- Presents the vector with a valid/ready handshake and holds it stable until the consumer accepts it.
- Also flags malformed frames, i.e. a frame-start marker arriving mid-frame.

---
 rtl/rw_mlp_feature_loader.sv | 131 +++++++++++++
 tb/tb_rw_mlp_feature_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rw_mlp_feature_loader.sv
// Serial feature loader for the red-wine MLP regressor: quantizes 8-bit samples and packs 11 of them into one vector.
// Build option: define RW_LOADER_QROUND_EN for round-to-nearest with saturation (default is truncation).
module rw_mlp_feature_loader #(
    parameter int N_FEAT = 11,
    parameter int IN_W   = 8,
    parameter int Q_W    = 4,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_FEAT*Q_W-1:0] out_data,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_FEAT*Q_W-1:0]   shadow_q, shadow_d;
    logic [N_FEAT*Q_W-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [Q_W-1:0]          q_sample;
    logic                    accept;

`ifdef RW_LOADER_QROUND_EN
    localparam logic [IN_W:0] RND_HALF = (IN_W+1)'(1) << (IN_W - Q_W - 1);
    logic [IN_W:0] rnd_sum;

    // Extra top bit catches the carry out of the rounding add; if set, saturate.
    always_comb begin
        rnd_sum  = {1'b0, in_data} + RND_HALF;
        q_sample = rnd_sum[IN_W] ? '1 : rnd_sum[IN_W-1:IN_W-Q_W];
    end
`else
    always_comb begin
        q_sample = in_data[IN_W-1:IN_W-Q_W];
    end
`endif

    assign in_ready  = ~rst && (state_q != ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_cnt   = err_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_first) begin
                    shadow_d          = '0;
                    shadow_d[Q_W-1:0] = q_sample;
                    idx_d             = ONE_IDX;
                    state_d           = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (in_first) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        shadow_d          = '0;
                        shadow_d[Q_W-1:0] = q_sample;
                        idx_d             = ONE_IDX;
                    end else begin
                        shadow_d[idx_q*Q_W +: Q_W] = q_sample;
                        if (idx_q == LAST_IDX) begin
                            // Output register loads the completed shadow in one step.
                            data_d  = shadow_d;
                            valid_d = 1'b1;
                            idx_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_rw_mlp_feature_loader.sv
// Directed self-checking bench for rw_mlp_feature_loader; expected vectors are hand-computed constants.
module tb_rw_mlp_feature_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_first = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [43:0] out_data;
    logic [7:0]  err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef RW_LOADER_QROUND_EN
    localparam logic [43:0] EXP_BASE  = 44'hCBA87654321;
    localparam logic [43:0] EXP_QUANT = 44'h00000000F87;
`else
    localparam logic [43:0] EXP_BASE  = 44'hBA987654321;
    localparam logic [43:0] EXP_QUANT = 44'h00000000F77;
`endif
    localparam logic [43:0] EXP_DESC  = 44'h0123456789A;

    rw_mlp_feature_loader #(.N_FEAT(11), .IN_W(8), .Q_W(4), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic first);
        in_valid = 1'b1;
        in_data  = d;
        in_first = first;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    // Ascending frame: sample i = 0x10 + 0x11*i.
    task automatic send_base_frame();
        for (int i = 0; i < 11; i++) begin
            send(8'(8'h10 + 8'h11 * i), i == 0);
        end
    endtask

    // Descending frame: sample i = ((10-i) << 4) | 3, features A..0.
    task automatic send_desc_frame();
        for (int i = 0; i < 11; i++) begin
            send(8'(((10 - i) << 4) | 3), i == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        tick();
        do_reset();

        // Basic frame with consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h10 + 8'h11 * i), i == 0);
        end
        check_eq("pre_last_valid", 64'(out_valid), 64'd0);
        send(8'hBA, 1'b0);
        check_eq("base_valid", 64'(out_valid), 64'd1);
        check_eq("base_data", 64'(out_data), 64'(EXP_BASE));
        check_eq("base_in_ready", 64'(in_ready), 64'd0);
        check_eq("base_err", 64'(err_cnt), 64'd0);
        tick();
        check_eq("base_valid_fall", 64'(out_valid), 64'd0);
        check_eq("base_ready_back", 64'(in_ready), 64'd1);
        check_eq("base_data_kept", 64'(out_data), 64'(EXP_BASE));

        // Quantization corner samples, then back-pressure for 20 cycles.
        out_ready = 1'b0;
        send(8'h77, 1'b1);
        send(8'h78, 1'b0);
        send(8'hFC, 1'b0);
        for (int i = 3; i < 11; i++) begin
            send(8'h00, 1'b0);
        end
        check_eq("quant_data", 64'(out_data), 64'(EXP_QUANT));
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 3) == 0;
            in_first = (c % 6) == 0;
            in_data  = 8'hEE;
            tick();
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_data", 64'(out_data), 64'(EXP_QUANT));
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        check_eq("bp_err", 64'(err_cnt), 64'd0);
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", 64'(out_valid), 64'd0);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);

        // Non-first samples in IDLE are dropped.
        for (int i = 0; i < 3; i++) begin
            send(8'hF0, 1'b0);
        end
        check_eq("idle_drop_valid", 64'(out_valid), 64'd0);
        send_base_frame();
        check_eq("idle_drop_data", 64'(out_data), 64'(EXP_BASE));
        check_eq("idle_drop_err", 64'(err_cnt), 64'd0);
        tick();

        // Frame restart after 5 samples.
        for (int i = 0; i < 5; i++) begin
            send(8'hF0, i == 0);
        end
        send_desc_frame();
        check_eq("restart_valid", 64'(out_valid), 64'd1);
        check_eq("restart_data", 64'(out_data), 64'(EXP_DESC));
        check_eq("restart_err", 64'(err_cnt), 64'd1);
        tick();

        // Saturation of the error counter.
        send(8'h11, 1'b1);
        for (int i = 0; i < 253; i++) begin
            send(8'h11, 1'b1);
        end
        check_eq("err_254", 64'(err_cnt), 64'd254);
        send(8'h11, 1'b1);
        check_eq("err_255", 64'(err_cnt), 64'd255);
        send(8'h11, 1'b1);
        send(8'h11, 1'b1);
        check_eq("err_sat", 64'(err_cnt), 64'd255);

        // Reset during HOLD.
        out_ready = 1'b0;
        for (int i = 1; i < 11; i++) begin
            send(8'(8'h10 + 8'h11 * i), 1'b0);
        end
        check_eq("hold_before_rst", 64'(out_valid), 64'd1);
        do_reset();

        // Reset after 6 FILL samples, then a clean frame.
        for (int i = 0; i < 6; i++) begin
            send(8'hF0, i == 0);
        end
        do_reset();
        out_ready = 1'b1;
        send_base_frame();
        check_eq("post_rst_valid", 64'(out_valid), 64'd1);
        check_eq("post_rst_data", 64'(out_data), 64'(EXP_BASE));
        check_eq("post_rst_err", 64'(err_cnt), 64'd0);
        tick();
        check_eq("post_rst_fall", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
